pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_duty_div.sv | 55 +++++
 rtl/pwm_capture.sv | 139 +++++++++++++
 tb/tb_pwm_capture.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Constants shared between the PWM generator and the PWM capture block,
// plus the capture FSM state type.
package pwm_pkg;
    localparam int CLK_HZ         = 50_000_000;
    localparam int PWM_PERIOD_CYC = 100000;
    localparam int DUTY_W         = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(255);
    localparam int CAP_TIMEOUT    = 2 * PWM_PERIOD_CYC;

    // state   | meaning
    // IDLE    | waiting for the first rise after reset or a stuck-level result
    // MEASURE | counting a period; the next rise closes the measurement
    // DIVIDE  | computing duty, up to and including the valid cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } cap_state_e;
endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// Callers guarantee num < den*256, so 8 iterations give the full quotient.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 18,
    parameter int NUM_W = CNT_W + DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              done,
    output logic [DUTY_W-1:0] quo
);
    logic [NUM_W-1:0]  rem;
    logic [NUM_W-1:0]  dsh;
    logic [DUTY_W-2:0] acc;
    logic [2:0]        step;
    logic              busy;
    logic              ge;

    assign ge   = (rem >= dsh);
    // done and quo are valid during the final iteration so the caller can
    // register the result on the same edge that retires it
    assign done = busy && (step == 3'd7);
    assign quo  = {acc, ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            dsh  <= '0;
            acc  <= '0;
            step <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= num;
            dsh  <= {1'b0, den, {(DUTY_W-1){1'b0}}};
            acc  <= '0;
            step <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (ge) begin
                rem <= rem - dsh;
            end
            dsh  <= dsh >> 1;
            acc  <= {acc[DUTY_W-3:0], ge};
            step <= step + 3'd1;
            if (step == 3'd7) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and 0-255 duty of an asynchronous PWM input,
// with a stuck-level result when no rising edge arrives within TIMEOUT cycles.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 18,
    parameter int TIMEOUT = CAP_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              valid,
    output logic              timeout
);
    localparam int NUM_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    cap_state_e state_q, state_d;

    logic              sync_a, s, s_d;
    logic              rise, fall;
    logic [CNT_W-1:0]  cnt, hcnt, h_cap, p_cap, hm_cap;
    logic [NUM_W-1:0]  num;
    logic [DUTY_W-1:0] div_quo;
    logic              div_start, div_done, res_load, to_load, to_hit;

    assign rise   = s & ~s_d;
    assign fall   = ~s & s_d;
    // fires once, on the step into saturation, so a stuck input reports once
    assign to_hit = ~rise && (cnt == CNT_LAST);
    assign num    = {h_cap, {DUTY_W{1'b0}}} - NUM_W'(h_cap);

    pwm_duty_div #(.CNT_W(CNT_W), .NUM_W(NUM_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (num),
        .den   (cnt),
        .done  (div_done),
        .quo   (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        res_load  = 1'b0;
        to_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end else if (to_hit) begin
                    to_load = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end else if (to_hit) begin
                    to_load = 1'b1;
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                res_load = div_done;
                // stay through the valid cycle so a rise there is dropped
                if (valid) begin
                    state_d = MEASURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_a    <= 1'b0;
            s         <= 1'b0;
            s_d       <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            h_cap     <= '0;
            p_cap     <= '0;
            hm_cap    <= '0;
            duty      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_a  <= pwm_in;
            s       <= sync_a;
            s_d     <= s;

            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (rise) begin
                hcnt <= CNT_W'(1);
            end else if (s && (hcnt != CNT_SAT)) begin
                hcnt <= hcnt + CNT_W'(1);
            end

            if (fall) begin
                h_cap <= hcnt;
            end

            if (div_start) begin
                p_cap  <= cnt;
                hm_cap <= h_cap;
            end

            valid <= 1'b0;
            if (res_load) begin
                duty      <= div_quo;
                period    <= p_cap;
                high_time <= hm_cap;
                timeout   <= 1'b0;
                valid     <= 1'b1;
            end else if (to_load) begin
                duty      <= s ? DUTY_MAX : '0;
                period    <= '0;
                high_time <= '0;
                timeout   <= 1'b1;
                valid     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: regular PWM, stuck levels, short periods
// and reset during a division, with hand-computed expected results.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W = 18;
    localparam int TO    = 400;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              valid;
    logic              timeout;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int vcount = 0;
    int vtick  = 0;
    int vfirst = -1;
    int base, r0, rr;
    logic [DUTY_W-1:0] v_duty;
    logic [CNT_W-1:0]  v_period, v_high;
    logic              v_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // sample on the falling edge, then drive the next input value
    task automatic tick(input logic p);
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            vcount++;
            vtick    = cyc;
            v_duty   = duty;
            v_period = period;
            v_high   = high_time;
            v_to     = timeout;
            if (vfirst < 0) vfirst = cyc;
        end
        pwm_in = p;
    endtask

    task automatic pwm_run(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++) tick(1'b1);
            for (int i = 0; i < l; i++) tick(1'b0);
        end
    endtask

    initial begin
        // reset with the input toggling: nothing may come out
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick(i[0]);
        tick(1'b0);
        tick(1'b0);
        check("rst_valid_cnt", vcount, 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0);

        // 30 high / 50 low, four periods: first rise arms, three results
        base = vcount; vfirst = -1; r0 = cyc + 1;
        pwm_run(30, 50, 4);
        check("p80_count", vcount - base, 3);
        check("p80_latency", vfirst, r0 + 80 + 11);
        check("p80_period", 32'(v_period), 80);
        check("p80_high", 32'(v_high), 30);
        check("p80_duty", 32'(v_duty), 95);
        check("p80_timeout", 32'(v_to), 0);

        // stuck high: one normal result, then one stuck-level result
        base = vcount; rr = cyc + 1;
        for (int i = 0; i < TO + 40; i++) tick(1'b1);
        check("hi_count", vcount - base, 2);
        check("hi_latency", vtick, rr + 2 + TO);
        check("hi_duty", 32'(v_duty), 255);
        check("hi_period", 32'(v_period), 0);
        check("hi_high", 32'(v_high), 0);
        check("hi_timeout", 32'(v_to), 1);
        check("hi_hold_to", 32'(timeout), 1);

        // falling back low while idle is not a new result
        base = vcount;
        for (int i = 0; i < 30; i++) tick(1'b0);
        check("idle_low_count", vcount - base, 0);

        // resume: first rise silent, second rise reports normally
        base = vcount; rr = cyc + 80 + 1;
        pwm_run(30, 50, 2);
        check("resume_count", vcount - base, 1);
        check("resume_duty", 32'(v_duty), 95);
        check("resume_timeout", 32'(v_to), 0);

        // stuck low after activity
        base = vcount;
        for (int i = 0; i < TO; i++) tick(1'b0);
        check("lo_count", vcount - base, 1);
        check("lo_latency", vtick, rr + 2 + TO);
        check("lo_duty", 32'(v_duty), 0);
        check("lo_period", 32'(v_period), 0);
        check("lo_timeout", 32'(v_to), 1);

        // period 6: every other rise falls into DIVIDE and is dropped
        base = vcount;
        pwm_run(3, 3, 10);
        for (int i = 0; i < 10; i++) tick(1'b0);
        check("p6_count", vcount - base, 5);
        check("p6_period", 32'(v_period), 6);
        check("p6_high", 32'(v_high), 3);
        check("p6_duty", 32'(v_duty), 127);
        check("p6_timeout", 32'(v_to), 0);

        // reset four cycles into a division
        base = vcount;
        for (int i = 0; i < 5; i++) tick(1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1);
        tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick(1'b0);
        check("rstdiv_count", vcount - base, 0);
        check("rstdiv_duty", 32'(duty), 0);
        check("rstdiv_period", 32'(period), 0);
        check("rstdiv_high", 32'(high_time), 0);
        check("rstdiv_timeout", 32'(timeout), 0);
        check("rstdiv_state", 32'(dut.state_q), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
